uart_rx_seg_frontend: RTL and testbench
=======================================

Name: uart_rx_seg_frontend

Overview:
Upstream stage of the word-detector chain. Receives 8N1 asynchronous serial data on the board UART pin and presents each accepted byte as RxD_data. It also presents a registered active-low 7-segment code as seg_data. A one-cycle Rx_detect strobe accompanies each accepted byte. Outputs connect directly to the word-detector FSM inputs of the same names.

Parameters:
CLK_FREQ, 50000000, system clock frequency in Hz.
BAUD, 115200, serial bit rate.
OVERSAMPLE, 16, sample ticks per bit; must be even and >= 8.
DIV, CLK_FREQ/(BAUD*OVERSAMPLE), derived localparam (integer division, 27 at defaults); elaboration error if < 2.

Ports:
clk  input  1  system clock; all logic is on the posedge.
rst  input  1  synchronous, active-high reset.
RxD  input  1  raw asynchronous serial line; idle high.
RxD_data  output  8  last accepted byte.
seg_data  output  8  active-low segment code of RxD_data; bit7 = DP, always 1.
Rx_detect  output  1  high for exactly one clk on byte acceptance.
frame_err  output  1  high for exactly one clk when the stop bit samples low.
rx_busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset: RxD_data=8'h00, seg_data=8'hFF, Rx_detect=0, frame_err=0, rx_busy=0, FSM=IDLE, sync flops=1, counters=0. Reset mid-frame aborts the frame with no strobe.
- Synchroniser: 2-FF on RxD; the FSM sees only the synchronised value rxs.
- Tick generator: counter 0..DIV-1; tick is asserted when the counter is DIV-1.
  - The counter is cleared on entry to START so that the phase aligns to the start edge.
- Sampling: each bit value is the majority of rxs at ticks OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1 of the bit. tick_cnt is 0..OVERSAMPLE-1.
- IDLE: when rxs==0, go to START.
- START: at the mid-bit vote, result 1 means a false start: return to IDLE with no outputs. Otherwise, at the end of the bit, go to DATA with bit_idx=0.
- DATA: 8 bits, LSB first, shifted into a shift register. After bit_idx==7 completes, go to STOP.
- STOP: at the mid-bit vote:
  - Vote 1: on the next clk, RxD_data<=shift, seg_data<=lookup(shift), Rx_detect=1 for that clk. Return to IDLE immediately (mid-stop-bit), so a back-to-back start bit is caught.
  - Vote 0: frame_err=1 for one clk, RxD_data and seg_data are unchanged, go to BREAK.
- BREAK: wait until rxs==1, then IDLE. A held-low line never produces bytes.
- Rx_detect and frame_err are never high together. RxD_data and seg_data hold from the strobe cycle until the next accepted byte.
- Lookup (combinational, registered at acceptance):
  - 'H'/'h'=8'b10001001
  - 'E'/'e'=8'b10000110
  - 'L'/'l'=8'b11000111
  - 'O'/'o'=8'b10100011
  - '0'..'9' = C0,F9,A4,B0,99,92,82,F8,80,90
  - space=8'hFF
  - CR/LF = hold the previous seg_data. RxD_data still updates and Rx_detect still pulses.
  - all others=8'hBF (dash).
- Latency: Rx_detect rises 1 clk after the stop-bit mid vote, about 9.5 bit periods after the start edge, plus 2 clk of synchroniser delay.

Decomposition:
- Shared package holds:
  - the segment constants SEG_H, SEG_E, SEG_L, SEG_O, SEG_BLANK=8'hFF, SEG_DASH=8'hBF, SEG_DIGIT[0:9];
  - the FSM state encoding IDLE/START/DATA/STOP/BREAK.
- The word detector imports the same SEG_* constants.
- One sub-module: ascii_to_seg (pure combinational, 8-bit ASCII in, 8-bit segment out, plus hold flag for CR/LF).

Test Plan:
- Send 0x48 ('H') at 115200 baud (432 clk/bit) -> one Rx_detect pulse, RxD_data=8'h48, seg_data=8'h89, frame_err stays 0.
- Send "HELLO" back-to-back with zero idle between stop and start -> exactly 5 Rx_detect pulses. seg_data sequence is 89,86,C7,C7,A3 (covers 'O'=0x4F).
- Send 0x6F then 0x0A -> first pulse gives seg_data=A3. Second pulse gives RxD_data=0A with seg_data still A3.
- 3-clk low glitch on RxD while idle -> START entered then aborted, rx_busy returns to 0, no Rx_detect, no frame_err.
- Frame 0x41 with stop bit forced low, line then held low 2 bit times -> one frame_err pulse, no Rx_detect, RxD_data/seg_data unchanged. A following good 0x35 yields seg_data=8'h92.
- Assert rst during DATA bit 4 of 0x48 -> no Rx_detect. Outputs return to reset values. The next full frame 0x45 is received correctly (seg_data=86).

Source files
------------

// File: rtl/uart_rx_seg_frontend_pkg.sv
// Shared constants for the UART front end and the downstream word detector:
// active-low 7-segment codes (bit7 = DP, kept dark) and the receiver state encoding.
package uart_rx_seg_frontend_pkg;

    localparam logic [7:0] SEG_H     = 8'b1000_1001;
    localparam logic [7:0] SEG_E     = 8'b1000_0110;
    localparam logic [7:0] SEG_L     = 8'b1100_0111;
    localparam logic [7:0] SEG_O     = 8'b1010_0011;
    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_DASH  = 8'hBF;

    localparam logic [7:0] SEG_DIGIT [0:9] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
        8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
    };

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } rx_state_e;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_seg_frontend_if.sv
// Output bundle of the UART front end as seen by the word-detector FSM.
interface uart_rx_seg_frontend_if;

    logic [7:0] RxD_data;
    logic [7:0] seg_data;
    logic       Rx_detect;
    logic       frame_err;
    logic       rx_busy;

    modport master (
        output RxD_data,
        output seg_data,
        output Rx_detect,
        output frame_err,
        output rx_busy
    );

    modport slave (
        input RxD_data,
        input seg_data,
        input Rx_detect,
        input frame_err,
        input rx_busy
    );

endinterface

// File: rtl/uart_rx_seg_frontend_ascii_to_seg.sv
// ASCII to active-low 7-segment decoder; CR/LF request that the previous code be kept.
module ascii_to_seg
    import uart_rx_seg_frontend_pkg::*;
(
    input  logic [7:0] ascii_i,
    output logic [7:0] seg_o,
    output logic       hold_o
);

    logic [9:0] digit_hit;

    genvar gi;
    for (gi = 0; gi < 10; gi++) begin : g_digit
        assign digit_hit[gi] = (ascii_i == 8'(8'h30 + gi));
    end

    always_comb begin
        seg_o  = SEG_DASH;
        hold_o = 1'b0;
        case (ascii_i)
            8'h48, 8'h68: seg_o = SEG_H;
            8'h45, 8'h65: seg_o = SEG_E;
            8'h4C, 8'h6C: seg_o = SEG_L;
            8'h4F, 8'h6F: seg_o = SEG_O;
            8'h20:        seg_o = SEG_BLANK;
            8'h0D, 8'h0A: hold_o = 1'b1;
            default: begin
                for (int i = 0; i < 10; i++) begin
                    if (digit_hit[i]) begin
                        seg_o = SEG_DIGIT[i];
                    end
                end
            end
        endcase
    end

endmodule

// File: rtl/uart_rx_seg_frontend.sv
// 8N1 UART receiver with 3-sample majority voting that registers each accepted byte
// together with its 7-segment code and strobes Rx_detect / frame_err for one clock.
module uart_rx_seg_frontend #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          RxD,
    uart_rx_seg_frontend_if.master        rx_o
);

    import uart_rx_seg_frontend_pkg::*;

    localparam int DIV   = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int DIV_W = (DIV > 2) ? $clog2(DIV) : 1;
    localparam int OS_W  = $clog2(OVERSAMPLE);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [OS_W-1:0]  T_LO     = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [OS_W-1:0]  T_MID    = OS_W'(OVERSAMPLE / 2);
    localparam logic [OS_W-1:0]  T_HI     = OS_W'(OVERSAMPLE / 2 + 1);
    localparam logic [OS_W-1:0]  T_LAST   = OS_W'(OVERSAMPLE - 1);

    if (DIV < 2) begin : g_div_check
        $error("uart_rx_seg_frontend: CLK_FREQ/(BAUD*OVERSAMPLE) must be at least 2");
    end
    if ((OVERSAMPLE < 8) || (OVERSAMPLE % 2 != 0)) begin : g_os_check
        $error("uart_rx_seg_frontend: OVERSAMPLE must be even and >= 8");
    end

    logic             rx_meta_q;
    logic             rxs_q;
    logic [DIV_W-1:0] div_cnt_q;
    logic [OS_W-1:0]  tick_cnt_q;
    logic             samp_lo_q;
    logic             samp_mid_q;
    rx_state_e        state_q;
    logic [2:0]       bit_idx_q;
    logic [7:0]       shift_q;
    logic [7:0]       rxd_data_q;
    logic [7:0]       seg_data_q;
    logic             rx_detect_q;
    logic             frame_err_q;

    logic             tick;
    logic             vote_now;
    logic             bit_end;
    logic             vote_d;
    logic [7:0]       seg_d;
    logic             seg_hold_d;

    assign tick     = (div_cnt_q == DIV_LAST);
    assign vote_now = tick && (tick_cnt_q == T_HI);
    assign bit_end  = tick && (tick_cnt_q == T_LAST);
    // The third sample is taken live on the vote tick, so the decision needs no extra cycle.
    assign vote_d   = majority3(samp_lo_q, samp_mid_q, rxs_q);

    ascii_to_seg u_ascii_to_seg (
        .ascii_i (shift_q),
        .seg_o   (seg_d),
        .hold_o  (seg_hold_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q   <= 1'b1;
            rxs_q       <= 1'b1;
            div_cnt_q   <= '0;
            tick_cnt_q  <= '0;
            samp_lo_q   <= 1'b1;
            samp_mid_q  <= 1'b1;
            state_q     <= IDLE;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            rxd_data_q  <= 8'h00;
            seg_data_q  <= 8'hFF;
            rx_detect_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            rx_meta_q   <= RxD;
            rxs_q       <= rx_meta_q;
            rx_detect_q <= 1'b0;
            frame_err_q <= 1'b0;

            div_cnt_q <= tick ? '0 : div_cnt_q + DIV_W'(1);
            if (tick) begin
                tick_cnt_q <= (tick_cnt_q == T_LAST) ? '0 : tick_cnt_q + OS_W'(1);
                if (tick_cnt_q == T_LO) begin
                    samp_lo_q <= rxs_q;
                end
                if (tick_cnt_q == T_MID) begin
                    samp_mid_q <= rxs_q;
                end
            end

            case (state_q)
                IDLE: begin
                    if (!rxs_q) begin
                        state_q    <= START;
                        div_cnt_q  <= '0;
                        tick_cnt_q <= '0;
                    end
                end
                START: begin
                    if (vote_now && vote_d) begin
                        state_q <= IDLE;
                    end else if (bit_end) begin
                        state_q   <= DATA;
                        bit_idx_q <= '0;
                    end
                end
                DATA: begin
                    if (vote_now) begin
                        shift_q <= {vote_d, shift_q[7:1]};
                    end
                    if (bit_end) begin
                        if (bit_idx_q == 3'd7) begin
                            state_q <= STOP;
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                        end
                    end
                end
                STOP: begin
                    // Leaving mid-stop-bit lets IDLE catch a start bit that follows immediately.
                    if (vote_now) begin
                        if (vote_d) begin
                            rxd_data_q  <= shift_q;
                            rx_detect_q <= 1'b1;
                            if (!seg_hold_d) begin
                                seg_data_q <= seg_d;
                            end
                            state_q <= IDLE;
                        end else begin
                            frame_err_q <= 1'b1;
                            state_q     <= BREAK;
                        end
                    end
                end
                BREAK: begin
                    if (rxs_q) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rx_o.RxD_data  = rxd_data_q;
    assign rx_o.seg_data  = seg_data_q;
    assign rx_o.Rx_detect = rx_detect_q;
    assign rx_o.frame_err = frame_err_q;
    assign rx_o.rx_busy   = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_seg_frontend.sv
// Scoreboard bench for uart_rx_seg_frontend: frames are driven at 432 clk/bit and each
// Rx_detect pops the expected byte/segment pair pushed when the frame was sent.
module tb_uart_rx_seg_frontend;

    localparam int BIT_CLK = 432;

    typedef struct packed {
        logic [7:0] data;
        logic [7:0] seg;
    } exp_t;

    logic clk;
    logic rst;
    logic RxD;

    uart_rx_seg_frontend_if rx_if ();

    uart_rx_seg_frontend dut (
        .clk  (clk),
        .rst  (rst),
        .RxD  (RxD),
        .rx_o (rx_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   checks   = 0;
    int   failures = 0;
    int   det_cnt  = 0;
    int   ferr_cnt = 0;
    int   pushed   = 0;
    exp_t exp_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [7:0] data, input logic [7:0] seg);
        exp_t e;
        e.data = data;
        e.seg  = seg;
        exp_q.push_back(e);
        pushed++;
    endtask

    task automatic bit_wait(input int n);
        repeat (n * BIT_CLK) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_val);
        RxD = 1'b0;
        bit_wait(1);
        for (int i = 0; i < 8; i++) begin
            RxD = b[i];
            bit_wait(1);
        end
        RxD = stop_val;
        bit_wait(1);
    endtask

    always @(negedge clk) begin
        if (!rst && rx_if.Rx_detect) begin
            det_cnt++;
            chk("ferr_with_detect", rx_if.frame_err, 1'b0);
            if (exp_q.size() == 0) begin
                chk("detect_vs_pushed", det_cnt, pushed);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                $display("rx byte %02h seg %02h (expect %02h/%02h)",
                         rx_if.RxD_data, rx_if.seg_data, e.data, e.seg);
                chk("rx_data", rx_if.RxD_data, e.data);
                chk("seg_data", rx_if.seg_data, e.seg);
            end
        end
        if (!rst && rx_if.frame_err) begin
            ferr_cnt++;
            $display("frame error observed");
        end
    end

    initial begin
        int d0;
        int f0;
        bit ok;
        logic [7:0] hello [0:4];
        logic [7:0] hello_seg [0:4];
        hello     = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F};
        hello_seg = '{8'h89, 8'h86, 8'hC7, 8'hC7, 8'hA3};

        rst = 1'b1;
        RxD = 1'b1;
        repeat (5) @(negedge clk);
        chk("rst_rxd_data", rx_if.RxD_data, 8'h00);
        chk("rst_seg_data", rx_if.seg_data, 8'hFF);
        chk("rst_detect", rx_if.Rx_detect, 1'b0);
        chk("rst_frame_err", rx_if.frame_err, 1'b0);
        chk("rst_busy", rx_if.rx_busy, 1'b0);
        rst = 1'b0;
        bit_wait(2);

        // Single 'H'
        d0 = det_cnt; f0 = ferr_cnt;
        push(8'h48, 8'h89);
        send_frame(8'h48, 1'b1);
        bit_wait(1);
        chk("h_count", det_cnt - d0, 1);
        chk("h_ferr", ferr_cnt - f0, 0);
        chk("h_data_hold", rx_if.RxD_data, 8'h48);
        chk("h_seg_hold", rx_if.seg_data, 8'h89);

        // "HELLO" back to back
        d0 = det_cnt;
        for (int i = 0; i < 5; i++) push(hello[i], hello_seg[i]);
        for (int i = 0; i < 5; i++) send_frame(hello[i], 1'b1);
        bit_wait(1);
        chk("hello_count", det_cnt - d0, 5);

        // 'o' then LF keeps the segment code
        d0 = det_cnt;
        push(8'h6F, 8'hA3);
        push(8'h0A, 8'hA3);
        send_frame(8'h6F, 1'b1);
        send_frame(8'h0A, 1'b1);
        bit_wait(1);
        chk("lf_count", det_cnt - d0, 2);

        // Short glitch while idle
        d0 = det_cnt; f0 = ferr_cnt;
        RxD = 1'b0;
        repeat (3) @(negedge clk);
        RxD = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rx_if.rx_busy) begin ok = 1'b1; break; end
        end
        chk("glitch_busy_rise", ok, 1'b1);
        ok = 1'b0;
        for (int i = 0; i < 2 * BIT_CLK; i++) begin
            @(negedge clk);
            if (!rx_if.rx_busy) begin ok = 1'b1; break; end
        end
        chk("glitch_busy_fall", ok, 1'b1);
        bit_wait(1);
        chk("glitch_detect", det_cnt - d0, 0);
        chk("glitch_ferr", ferr_cnt - f0, 0);

        // Framing error then line held low
        d0 = det_cnt; f0 = ferr_cnt;
        send_frame(8'h41, 1'b0);
        RxD = 1'b0;
        bit_wait(2);
        chk("break_busy", rx_if.rx_busy, 1'b1);
        RxD = 1'b1;
        bit_wait(2);
        chk("ferr_count", ferr_cnt - f0, 1);
        chk("ferr_detect", det_cnt - d0, 0);
        chk("ferr_data_kept", rx_if.RxD_data, 8'h0A);
        chk("ferr_seg_kept", rx_if.seg_data, 8'hA3);
        chk("break_idle", rx_if.rx_busy, 1'b0);
        push(8'h35, 8'h92);
        send_frame(8'h35, 1'b1);
        bit_wait(1);
        chk("after_ferr_count", det_cnt - d0, 1);

        // Reset in the middle of data bit 4 of 'H'
        d0 = det_cnt;
        RxD = 1'b0;
        bit_wait(1);
        for (int i = 0; i < 4; i++) begin
            RxD = (i == 3) ? 1'b1 : 1'b0;
            bit_wait(1);
        end
        RxD = 1'b0;
        repeat (BIT_CLK / 2) @(negedge clk);
        chk("mid_busy", rx_if.rx_busy, 1'b1);
        rst = 1'b1;
        RxD = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_data", rx_if.RxD_data, 8'h00);
        chk("mid_rst_seg", rx_if.seg_data, 8'hFF);
        chk("mid_rst_busy", rx_if.rx_busy, 1'b0);
        bit_wait(6);
        chk("mid_rst_detect", det_cnt - d0, 0);
        push(8'h45, 8'h86);
        send_frame(8'h45, 1'b1);
        bit_wait(1);
        chk("post_rst_count", det_cnt - d0, 1);

        chk("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
